// File: rtl/sign_extend_if.sv
// Immediate-extender bus: 16-bit immediate and mode in, combinational and registered results out.
// neg_count is present only when SIGN_EXTEND_STATS_EN is defined.
interface sign_extend_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
);
  // Valid-only handshake: in_valid qualifies in_imm/mode for the cycle it is high.
  // There is no ready, so the extender accepts a new immediate on every edge,
  // and out_valid simply follows in_valid one edge later.
  logic [IN_WIDTH-1:0]  in_imm;
  logic [1:0]           mode;
  logic                 in_valid;
  logic [OUT_WIDTH-1:0] out_ext;
  logic                 out_neg;
  logic [OUT_WIDTH-1:0] out_reg;
  logic                 out_valid;
`ifdef SIGN_EXTEND_STATS_EN
  logic [15:0]          neg_count;
`endif

  modport master (
    output in_imm, mode, in_valid,
    input  out_ext, out_neg, out_reg, out_valid
`ifdef SIGN_EXTEND_STATS_EN
    , input neg_count
`endif
  );

  modport slave (
    input  in_imm, mode, in_valid,
    output out_ext, out_neg, out_reg, out_valid
`ifdef SIGN_EXTEND_STATS_EN
    , output neg_count
`endif
  );
endinterface

// File: rtl/sign_extend.sv
// ID-stage immediate extender: sign/zero/branch-offset/LUI widening, plus an ID/EX registered copy.
// Optional SIGN_EXTEND_STATS_EN adds a saturating count of valid negative immediates.
module sign_extend #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  sign_extend_if.slave bus
);

  // Branch mode needs two spare bits above the immediate for the <<2.
  generate
    if (OUT_WIDTH < IN_WIDTH + 2) begin : g_width_check
      $error("sign_extend: OUT_WIDTH must be at least IN_WIDTH+2");
    end
  endgenerate

  localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

  typedef enum logic [1:0] {
    MODE_SEXT   = 2'b00,
    MODE_ZEXT   = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_LUI    = 2'b11
  } mode_e;

  mode_e                mode_sel;
  logic                 msb;
  logic [OUT_WIDTH-1:0] sext;
  logic [OUT_WIDTH-1:0] zext;
  logic [OUT_WIDTH-1:0] brof;
  logic [OUT_WIDTH-1:0] lui;
  logic [OUT_WIDTH-1:0] ext;
  logic                 neg;
  logic [OUT_WIDTH-1:0] reg_q;
  logic                 valid_q;

  assign mode_sel = mode_e'(bus.mode);
  assign msb      = bus.in_imm[IN_WIDTH-1];
  assign sext     = {{EXT_W{msb}}, bus.in_imm};
  assign zext     = {{EXT_W{1'b0}}, bus.in_imm};
  // Bits pushed past the top by the word-offset shift are simply dropped.
  assign brof     = {sext[OUT_WIDTH-3:0], 2'b00};
  assign lui      = zext << IN_WIDTH;

  always_comb begin
    ext = sext;
    neg = 1'b0;
    case (mode_sel)
      MODE_SEXT: begin
        ext = sext;
        neg = msb;
      end
      MODE_ZEXT: begin
        ext = zext;
      end
      MODE_BRANCH: begin
        ext = brof;
        neg = msb;
      end
      MODE_LUI: begin
        ext = lui;
      end
      default: begin
        ext = sext;
        neg = 1'b0;
      end
    endcase
  end

  assign bus.out_ext = ext;
  assign bus.out_neg = neg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        reg_q <= ext;
      end
    end
  end

  assign bus.out_reg   = reg_q;
  assign bus.out_valid = valid_q;

`ifdef SIGN_EXTEND_STATS_EN
  logic [15:0] neg_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_cnt <= '0;
    end else if (bus.in_valid && neg && (neg_cnt != 16'hFFFF)) begin
      neg_cnt <= neg_cnt + 16'd1;
    end
  end

  assign bus.neg_count = neg_cnt;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: directed test-plan steps, then randomized traffic
// checked against an arithmetic reference model and a registered-output expected queue.
module tb_sign_extend;

  localparam int IW = 16;
  localparam int OW = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  // Each entry is {expected out_valid, expected out_reg} for the next edge.
  logic [OW:0] exp_q[$];
  logic [OW-1:0] exp_reg;

  sign_extend_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  sign_extend #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret the immediate as a signed number and widen arithmetically.
  function automatic logic [OW-1:0] model_ext(input logic [IW-1:0] imm, input logic [1:0] m);
    longint v;
    longint s;
    longint r;
    v = longint'(imm);
    s = (v >= 32768) ? v - 65536 : v;
    case (m)
      2'd0:    r = s;
      2'd1:    r = v;
      2'd2:    r = s * 4;
      default: r = v * 65536;
    endcase
    return OW'(r & 64'hFFFF_FFFF);
  endfunction

  function automatic logic model_neg(input logic [IW-1:0] imm, input logic [1:0] m);
    return (int'(imm) >= 32768) && (m == 2'd0 || m == 2'd2);
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [IW-1:0] imm, input logic [1:0] m, input logic v);
    @(negedge clk);
    bus.in_imm   = imm;
    bus.mode     = m;
    bus.in_valid = v;
  endtask

  task automatic check_comb(input string tag, input logic [IW-1:0] imm, input logic [1:0] m);
    check({tag, "_ext"}, bus.out_ext, model_ext(imm, m));
    check({tag, "_neg"}, OW'(bus.out_neg), OW'(model_neg(imm, m)));
  endtask

  initial begin
    logic [IW-1:0] imm;
    logic [1:0]    m;
    logic          v;
    logic [OW:0]   e;
    n_checks     = 0;
    n_errors     = 0;
    exp_reg      = '0;
    reset        = 1'b1;
    bus.in_imm   = '0;
    bus.mode     = 2'b00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_reg", bus.out_reg, 32'h0);
    check("rst_out_valid", OW'(bus.out_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Combinational values, each held 100 time units
    bus.mode = 2'b00; bus.in_imm = 16'h8000; #100;
    check("sext_8000", bus.out_ext, 32'hFFFF8000);
    check("sext_8000_neg", OW'(bus.out_neg), 32'h1);
    bus.in_imm = 16'h2000; #100; check("sext_2000", bus.out_ext, 32'h00002000);
    bus.in_imm = 16'h6000; #100; check("sext_6000", bus.out_ext, 32'h00006000);
    bus.in_imm = 16'hFFFF; #100; check("sext_ffff", bus.out_ext, 32'hFFFFFFFF);
    bus.in_imm = 16'h7FFF; #100; check("sext_7fff", bus.out_ext, 32'h00007FFF);
    bus.mode = 2'b01; bus.in_imm = 16'h8000; #100;
    check("zext_8000", bus.out_ext, 32'h00008000);
    check("zext_8000_neg", OW'(bus.out_neg), 32'h0);
    bus.mode = 2'b11; bus.in_imm = 16'h1234; #100; check("lui_1234", bus.out_ext, 32'h12340000);
    bus.mode = 2'b10; bus.in_imm = 16'hFFFF; #100; check("br_ffff", bus.out_ext, 32'hFFFFFFFC);
    bus.in_imm = 16'h0001; #100; check("br_0001", bus.out_ext, 32'h00000004);
    bus.in_imm = 16'h8000; #100; check("br_8000", bus.out_ext, 32'hFFFE0000);
    bus.in_imm = 16'h7FFF; #100; check("br_7fff", bus.out_ext, 32'h0001FFFC);
    for (int k = 0; k < 4; k++) begin
      bus.mode = 2'(k); bus.in_imm = 16'h0000; #10;
      check("zero_all_modes", bus.out_ext, 32'h0);
    end

    // Registered capture then hold
    drive(16'h8000, 2'b00, 1'b1);
    @(posedge clk); #1;
    check("cap_out_reg", bus.out_reg, 32'hFFFF8000);
    check("cap_out_valid", OW'(bus.out_valid), 32'h1);
    drive(16'h1234, 2'b01, 1'b0);
    @(posedge clk); #1;
    check("hold_out_reg", bus.out_reg, 32'hFFFF8000);
    check("hold_out_valid", OW'(bus.out_valid), 32'h0);

    // Asynchronous reset between edges, with a valid value captured
    drive(16'h4321, 2'b11, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_out_reg", bus.out_reg, 32'h43210000);
    check("pre_rst_out_valid", OW'(bus.out_valid), 32'h1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_reg", bus.out_reg, 32'h0);
    check("async_rst_out_valid", OW'(bus.out_valid), 32'h0);
    check("async_rst_out_ext", bus.out_ext, 32'h43210000);
    @(posedge clk); #1;
    check("held_rst_out_reg", bus.out_reg, 32'h0);
    check("held_rst_out_valid", OW'(bus.out_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_cap_out_reg", bus.out_reg, 32'h43210000);

`ifdef SIGN_EXTEND_STATS_EN
    @(negedge clk); reset = 1'b1; #1;
    check("stats_rst", OW'(bus.neg_count), 32'h0);
    reset = 1'b0;
    drive(16'h8001, 2'b00, 1'b1);
    drive(16'h0005, 2'b00, 1'b1);
    drive(16'hF000, 2'b10, 1'b1);
    drive(16'h8000, 2'b01, 1'b0);
    drive(16'h7FFF, 2'b10, 1'b1);
    drive(16'hFFFF, 2'b00, 1'b1);
    drive(16'h0000, 2'b00, 1'b0);
    @(posedge clk); #1;
    check("stats_count3", OW'(bus.neg_count), 32'h3);
    @(negedge clk); reset = 1'b1; #1;
    check("stats_rst_again", OW'(bus.neg_count), 32'h0);
    reset = 1'b0;
`endif

    // Randomized traffic; out_reg before this phase is whatever was last captured
    exp_reg = bus.out_reg === 32'h0 ? 32'h0 : 32'h43210000;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       imm = 16'h8000;
        1:       imm = 16'h7FFF;
        2:       imm = 16'hFFFF;
        default: imm = IW'($urandom);
      endcase
      m = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      drive(imm, m, v);
      #1;
      check_comb("rand", imm, m);
      if (v) exp_reg = model_ext(imm, m);
      exp_q.push_back({v, exp_reg});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check("rand_out_reg", bus.out_reg, e[OW-1:0]);
      check("rand_out_valid", OW'(bus.out_valid), OW'(e[OW]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
